// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the packet-locked round-robin arbiter.
//   arb_state_t      : arbiter FSM state (IDLE, LOCKED)
//   MAX_REQ          : widest one-hot vector onehot_to_index accepts
//   onehot_to_index  : binary index of the set bit of a one-hot vector (0 when empty)
package rr_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_REQ = 64;

    // Callers zero-extend their vector to MAX_REQ bits; result is the highest set bit.
    function automatic int unsigned onehot_to_index(input logic [MAX_REQ-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arbitration_algorithm.sv
// Combinational round-robin next-grant computation.
//   input_valid   : per-requester request
//   current_ready : current one-hot grant (rotation pointer)
//   last_ready    : previous one-hot grant, used as pointer when current_ready is empty
//   next_ready    : one-hot grant to the first valid requester above the pointer, wrapping;
//                   lowest valid index when both pointers are empty
module arbitration_algorithm
    import rr_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 8
) (
    input  logic [N_REQ-1:0] input_valid,
    input  logic [N_REQ-1:0] current_ready,
    input  logic [N_REQ-1:0] last_ready,
    output logic [N_REQ-1:0] next_ready
);

    localparam int unsigned IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] ptr;
    int unsigned      base;
    int unsigned      sum;
    logic             found;

    assign ptr = (|current_ready) ? current_ready : last_ready;

    // Search starts one above the pointer; an empty pointer starts the search at index 0.
    always_comb begin
        next_ready = '0;
        found      = 1'b0;
        sum        = 0;
        base       = (|ptr) ? onehot_to_index(MAX_REQ'(ptr)) : (N_REQ - 1);
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            sum = base + k;
            if (sum >= N_REQ) sum = sum - N_REQ;
            if (!found && input_valid[IDXW'(sum)]) begin
                next_ready[IDXW'(sum)] = 1'b1;
                found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Packet-locked round-robin arbiter: grants one requester for a whole packet,
// muxes its beats into a single registered valid/ready output port.
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : per-requester beat valid
//   in_data     : packed requester data, requester i at [i*DATAW +: DATAW]
//   in_last     : per-requester last-beat flag
//   in_ready    : per-requester ready (at most one bit set)
//   out_valid/out_data/out_last/out_src : registered output beat and its source index
//   out_ready   : downstream ready
module rr_packet_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 8,
    parameter int unsigned DATAW = 64,
    parameter int unsigned SRCW  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       in_valid,
    input  logic [N_REQ*DATAW-1:0] in_data,
    input  logic [N_REQ-1:0]       in_last,
    output logic [N_REQ-1:0]       in_ready,
    output logic                   out_valid,
    output logic [DATAW-1:0]       out_data,
    output logic                   out_last,
    output logic [SRCW-1:0]        out_src,
    input  logic                   out_ready
);

    arb_state_t       state, state_next;
    logic [N_REQ-1:0] grant, grant_next;
    logic [N_REQ-1:0] prev_grant, prev_grant_next;
    logic [N_REQ-1:0] next_ready;
    logic [SRCW-1:0]  grant_idx;
    logic             accept;
    logic             transfer;
    logic             out_valid_next;
    logic [DATAW-1:0] out_data_next;
    logic             out_last_next;
    logic [SRCW-1:0]  out_src_next;
    logic [DATAW-1:0] req_data [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_data[i] = in_data[i*DATAW +: DATAW];
    end

    // Grant register doubles as the rotation pointer for the next arbitration.
    arbitration_algorithm #(.N_REQ(N_REQ)) u_algo (
        .input_valid   (in_valid),
        .current_ready (grant),
        .last_ready    (prev_grant),
        .next_ready    (next_ready)
    );

    assign grant_idx = SRCW'(onehot_to_index(MAX_REQ'(grant)));
    assign accept    = !out_valid || out_ready;

    // Next-state and output-register load logic.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        prev_grant_next = prev_grant;
        in_ready        = '0;
        transfer        = 1'b0;
        out_valid_next  = out_valid;
        out_data_next   = out_data;
        out_last_next   = out_last;
        out_src_next    = out_src;
        case (state)
            IDLE: begin
                if (|in_valid) begin
                    grant_next      = next_ready;
                    prev_grant_next = grant;
                    state_next      = LOCKED;
                end
            end
            LOCKED: begin
                in_ready = grant & {N_REQ{accept}};
                transfer = |(in_valid & in_ready);
                if (transfer) begin
                    out_valid_next = 1'b1;
                    out_data_next  = req_data[grant_idx];
                    out_last_next  = in_last[grant_idx];
                    out_src_next   = grant_idx;
                    if (in_last[grant_idx]) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!transfer && out_valid && out_ready) out_valid_next = 1'b0;
    end

    // State, grant and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            prev_grant <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_src    <= '0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            prev_grant <= prev_grant_next;
            out_valid  <= out_valid_next;
            out_data   <= out_data_next;
            out_last   <= out_last_next;
            out_src    <= out_src_next;
        end
    end

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
    a_locked_grant  : assert property (@(posedge clk) disable iff (rst) (state == LOCKED) |-> (grant != '0));
    a_out_stable    : assert property (@(posedge clk) disable iff (rst)
                          (out_valid && !out_ready) |=> (out_valid && $stable(out_data)
                                                         && $stable(out_last) && $stable(out_src)));

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Self-checking bench for rr_packet_arbiter (N_REQ=4, DATAW=8): directed
// scenarios with literal expectations plus a randomized run against a
// behavioural round-robin packet model.
module tb_rr_packet_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned SW = 2;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    typedef struct {
        int           cyc;
        int           src;
        logic [W-1:0] d;
        logic         l;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_last = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_src;
    logic           out_ready = 1'b0;

    rr_packet_arbiter #(.N_REQ(N), .DATAW(W), .SRCW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    beat_t        q [N][$];
    ev_t          evq[$];
    logic [N-1:0] ir_hist[$];
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    bit           rnd_mode = 1'b0;
    logic [N-1:0] hold = '0;
    logic         ordy = 1'b1;

    // Model: locked owner, rotation pointer (-1 = none yet), output register.
    bit           m_locked = 1'b0;
    int           m_owner = 0;
    int           m_ptr = -1;
    bit           m_ov = 1'b0;
    logic [W-1:0] m_od = '0;
    bit           m_ol = 1'b0;
    int           m_os = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_ev(input int k, input int src, input logic [W-1:0] d, input bit l, input int c);
        n_chk++;
        if (k >= evq.size()) begin
            n_fail++;
            $display("FAIL event[%0d]: got none (only %0d beats) expected src %0d data %0h", k, evq.size(), src, d);
        end else if (evq[k].src != src || evq[k].d !== d || evq[k].l !== l || (c >= 0 && evq[k].cyc != c)) begin
            n_fail++;
            $display("FAIL event[%0d]: got src %0d data %0h last %0b cyc %0d expected src %0d data %0h last %0b cyc %0d",
                     k, evq[k].src, evq[k].d, evq[k].l, evq[k].cyc, src, d, l, c);
        end
    endtask

    task automatic add_pkt(input int r, input int len, input logic [W-1:0] d0);
        for (int k = 0; k < len; k++) q[r].push_back('{d: d0 + W'(k), l: (k == len - 1)});
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        m_locked = 1'b0; m_ptr = -1; m_owner = 0;
        m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_os = 0;
        hold = '0;
        ordy = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        evq.delete();
    endtask

    // One clock cycle: drive, check ready, advance model, check registered outputs.
    task automatic step();
        logic [N-1:0]   v, lst, exp_ir;
        logic [N*W-1:0] dat;
        bit             acc, xfer, found, ov_b, or_b;
        beat_t          b;
        int             idx;
        v = '0; lst = '0; dat = '0;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && !hold[i] && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
                v[i]           = 1'b1;
                lst[i]         = q[i][0].l;
                dat[i*W +: W]  = q[i][0].d;
            end
        end
        in_valid  = v;
        in_last   = lst;
        in_data   = dat;
        out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ordy;
        #1;
        acc    = !m_ov || out_ready;
        exp_ir = (m_locked && acc) ? N'(1 << m_owner) : '0;
        ir_hist.push_back(in_ready);
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        ov_b = out_valid;
        or_b = out_ready;
        xfer = 1'b0;
        if (!m_locked) begin
            if (|v) begin
                found = 1'b0;
                for (int k = 1; k <= int'(N); k++) begin
                    idx = (m_ptr + k + int'(N)) % int'(N);
                    if (!found && v[idx]) begin
                        m_owner = idx;
                        found   = 1'b1;
                    end
                end
                m_ptr    = m_owner;
                m_locked = 1'b1;
            end
        end else if (v[m_owner] && acc) begin
            xfer = 1'b1;
            b    = q[m_owner].pop_front();
            m_ov = 1'b1; m_od = b.d; m_ol = b.l; m_os = m_owner;
            if (b.l) m_locked = 1'b0;
        end
        if (!xfer && m_ov && out_ready) m_ov = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", 32'(out_data), 32'(m_od));
            chk("out_last", 32'(out_last), 32'(m_ol));
            chk("out_src", 32'(out_src), 32'(m_os));
        end
        if (out_valid && (!ov_b || or_b)) evq.push_back('{cyc, int'(out_src), out_data, out_last});
        cyc++;
    endtask

    initial begin
        int c0;
        int pending;
        int guard;

        // Reset values
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);

        // Single 3-beat packet from requester 2
        do_reset();
        add_pkt(2, 3, 8'hA1);
        c0 = cyc;
        repeat (5) step();
        chk("t1_ready_idle", 32'(ir_hist[c0]), 32'h0);
        chk("t1_ready_grant", 32'(ir_hist[c0+1]), 32'h4);
        chk("t1_count", 32'(evq.size()), 32'd3);
        chk_ev(0, 2, 8'hA1, 1'b0, c0 + 1);
        chk_ev(1, 2, 8'hA2, 1'b0, c0 + 2);
        chk_ev(2, 2, 8'hA3, 1'b1, c0 + 3);

        // All four requesters, single-beat packets: rotation 0,1,2,3,0
        do_reset();
        add_pkt(0, 1, 8'h10); add_pkt(1, 1, 8'h20); add_pkt(2, 1, 8'h30);
        add_pkt(3, 1, 8'h40); add_pkt(0, 1, 8'h11);
        c0 = cyc;
        repeat (12) step();
        chk("t2_count", 32'(evq.size()), 32'd5);
        chk_ev(0, 0, 8'h10, 1'b1, c0 + 1);
        chk_ev(1, 1, 8'h20, 1'b1, c0 + 3);
        chk_ev(2, 2, 8'h30, 1'b1, c0 + 5);
        chk_ev(3, 3, 8'h40, 1'b1, c0 + 7);
        chk_ev(4, 0, 8'h11, 1'b1, c0 + 9);

        // Granted requester 1 stalls mid-packet while requester 3 waits
        do_reset();
        add_pkt(1, 4, 8'h50);
        add_pkt(3, 1, 8'h60);
        hold = 4'b1000;
        c0 = cyc;
        step(); step();
        hold = 4'b0010;
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            chk("t3_ready3_low", 32'(ir_hist[c0+2+k][3]), 32'd0);
            chk("t3_ready1_held", 32'(ir_hist[c0+2+k]), 32'h2);
        end
        hold = '0;
        repeat (8) step();
        chk("t3_count", 32'(evq.size()), 32'd5);
        for (int k = 0; k < 4; k++) chk_ev(k, 1, 8'h50 + W'(k), k == 3, -1);
        chk_ev(4, 3, 8'h60, 1'b1, c0 + 9);

        // Downstream back-pressure for 4 cycles
        do_reset();
        add_pkt(2, 4, 8'h70);
        step(); step();
        ordy = 1'b0;
        repeat (4) begin
            step();
            chk("t4_stall_valid", 32'(out_valid), 32'd1);
            chk("t4_stall_data", 32'(out_data), 32'h70);
            chk("t4_stall_ready", 32'(ir_hist[cyc-1]), 32'h0);
        end
        ordy = 1'b1;
        repeat (6) step();
        chk("t4_count", 32'(evq.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk_ev(k, 2, 8'h70 + W'(k), k == 3, -1);

        // Lone requester 0, two back-to-back 2-beat packets
        do_reset();
        add_pkt(0, 2, 8'h80);
        add_pkt(0, 2, 8'h82);
        c0 = cyc;
        repeat (8) step();
        chk("t5_count", 32'(evq.size()), 32'd4);
        chk_ev(0, 0, 8'h80, 1'b0, c0 + 1);
        chk_ev(1, 0, 8'h81, 1'b1, c0 + 2);
        chk_ev(2, 0, 8'h82, 1'b0, c0 + 4);
        chk_ev(3, 0, 8'h83, 1'b1, c0 + 5);

        // Asynchronous reset during beat 2 of a 4-beat packet
        do_reset();
        add_pkt(2, 4, 8'h90);
        step(); step(); step();
        chk("t6_beat2_valid", 32'(out_valid), 32'd1);
        chk("t6_beat2_data", 32'(out_data), 32'h91);
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_ready", 32'(in_ready), 32'd0);
        do_reset();
        add_pkt(3, 1, 8'hA0);
        add_pkt(1, 1, 8'hB0);
        c0 = cyc;
        repeat (5) step();
        chk_ev(0, 1, 8'hB0, 1'b1, c0 + 1);
        chk_ev(1, 3, 8'hA0, 1'b1, c0 + 3);

        // Randomized traffic against the model
        do_reset();
        rnd_mode = 1'b1;
        repeat (3000) begin
            for (int i = 0; i < int'(N); i++)
                if (q[i].size() == 0 && $urandom_range(0, 7) == 0)
                    add_pkt(i, int'($urandom_range(1, 4)), W'($urandom));
            step();
        end
        guard = 0;
        pending = 1;
        while (pending != 0 && guard < 400) begin
            pending = 0;
            for (int i = 0; i < int'(N); i++) pending += q[i].size();
            if (pending != 0) step();
            guard++;
        end
        chk("drain_pending", 32'(pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Packet-locked round-robin arbiter datapath that sits directly downstream of arbitration_algorithm.
- Registers the one-hot grant, holds it for a whole packet (until the last beat), muxes the granted requester's data/last, and drives a single registered valid/ready output port.
- Feeds the grant register back as current_ready/last_ready, so the combinational algorithm rotates priority.

Parameters:
- N_REQ, 8, number of requesters (>=2).
- DATAW, 64, data bus width per requester.
- SRCW, $clog2(N_REQ), width of the source-index output.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N_REQ  per-requester beat valid.
- in_data  input  N_REQ*DATAW  packed requester data; requester i occupies [i*DATAW +: DATAW].
- in_last  input  N_REQ  per-requester last-beat flag.
- in_ready  output  N_REQ  per-requester ready; at most one bit set.
- out_valid  output  1  output beat valid.
- out_data  output  DATAW  output beat data.
- out_last  output  1  output last-beat flag.
- out_src  output  SRCW  binary index of the requester that produced the beat.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset values: state=IDLE, grant=0, prev_grant=0, out_valid=0, out_data=0, out_last=0, out_src=0, in_ready=0.
- Sub-module wiring: input_valid=in_valid, current_ready=grant, last_ready=prev_grant. The result is next_ready.
- grant=0 out of reset: the algorithm picks the lowest-index valid requester.
- Output register accept condition: accept = !out_valid || out_ready.
- FSM IDLE:
  - in_ready=0.
  - If |in_valid, then grant<=next_ready, prev_grant<=grant, state<=LOCKED.
  - Otherwise hold.
  - The arbitration decision costs exactly one cycle.
- FSM LOCKED:
  - in_ready = grant & {N_REQ{accept}}.
  - A beat transfers when (in_valid & in_ready) != 0.
  - On transfer: out_data/out_last/out_src are loaded from the granted requester, and out_valid<=1.
  - On transfer with in_last: state<=IDLE. grant is kept, so it is the rotation pointer for the next arbitration.
- If out_valid && out_ready with no new transfer, then out_valid<=0.
- Throughput: one beat/cycle sustained in LOCKED when out_ready=1. Each packet incurs one IDLE bubble.
- Latency: granted in_valid to out_valid is 1 cycle.
- Granted requester deasserts in_valid mid-packet: stay LOCKED and wait. Other requesters are never granted until the last beat.
- Non-granted requester asserting in_valid: ignored; its in_ready stays 0.
- Last beat transfers while other requesters are valid: go IDLE, then grant the next higher index (wrapping) on the following cycle.
- A lone requester sending back-to-back packets is re-granted after one bubble; the algorithm wraps to it.
- out_ready low with out_valid=1: out_data/out_last/out_src stay stable, and in_ready=0.
- Asynchronous rst mid-packet: everything immediately returns to its reset values. The partial packet is dropped and not resumed.
- Invariants (assertions):
  - $onehot0(grant) and $onehot0(in_ready).
  - In LOCKED, grant != 0.
  - out_* stable while out_valid && !out_ready.

Decomposition:
- Shared package rr_arb_pkg holds:
  - typedef enum logic {IDLE, LOCKED} arb_state_t;
  - a function onehot_to_index(N_REQ) used for out_src.
- One sub-module is instantiated: the existing arbitration_algorithm (next-grant computation). No other hierarchy.

Test Plan (N_REQ=4, DATAW=8):
- Reset, then in_valid=4'b0100 with a 3-beat packet (0xA1,0xA2,0xA3 last) and out_ready=1.
  - Grant is 4'b0100 one cycle later.
  - out beats are 0xA1..0xA3 on consecutive cycles, out_src=2, out_last on 0xA3.
- All four requesters valid with 1-beat packets, out_ready=1.
  - out_src sequence is 0,1,2,3,0.
  - Each packet is separated by one idle cycle.
- Requester 1 in mid-packet (grant=4'b0010) drops in_valid for 3 cycles while requester 3 is valid.
  - No requester-3 beats appear; in_ready[3]=0 throughout.
  - Requester 1 resumes and its packet completes.
- out_ready held 0 for 4 cycles during a packet.
  - out_valid=1 and out_data is stable.
  - in_ready=4'b0000 until out_ready returns, with no beat lost or duplicated.
- Lone requester 0 sends 2 back-to-back 2-beat packets.
  - Both packets are output in order, out_src=0, with a single bubble between them.
- Assert rst during beat 2 of a 4-beat packet.
  - Next cycle: out_valid=0, in_ready=0, state IDLE.
  - After release, arbitration starts from the lowest valid index.
